// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - stream framing constant (bytes per instruction word)
//   - helper: which states accept a stream byte
package instr_mem_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR0  = 3'd1;
  localparam logic [2:0] ST_HDR1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  localparam int WORD_BYTES = 4;

  // Byte-accepting states; also the states in which the idle timer runs.
  function automatic logic st_accepts(input logic [2:0] s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/instr_mem_loader_timeout.sv
// loader_timeout: idle-cycle watchdog for the stream loader.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : restart the idle count (byte accepted / timer not armed)
//   en_i           : count this cycle
//   expired_o      : 1-cycle pulse on the TIMEOUT-th consecutive idle cycle
// TIMEOUT == 0 disables the watchdog entirely.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = clk_i ^ rst_n_i ^ clr_i ^ en_i;
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;

    // cnt_q holds the number of idle cycles already seen, so the cycle
    // where it equals TIMEOUT-1 is the TIMEOUT-th idle cycle.
    assign hit       = (cnt_q == CW'(TIMEOUT - 1));
    assign expired_o = en_i & ~clr_i & hit;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = hit ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: fills the instruction memory from a byte stream.
// Stream: 16-bit LE word count N, then N little-endian 32-bit words.
//   clk_i, rst_n_i         : clock, async active-low reset
//   start_i                : begin a load (honoured in IDLE/DONE/ERR)
//   byte_data_i/valid_i    : stream byte in; byte_ready_o completes handshake
//   mem_we_o/addr_o/wdata_o: one write strobe per word, byte address idx*4
//   busy_o                 : load in progress (holds core in reset)
//   done_o / error_o       : sticky outcome of the last load
//   words_loaded_o         : words written by the current/last load
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] asm_q, asm_d;      // low 3 bytes; byte 3 goes straight to wdata
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;      // doubles as the words-loaded count
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ready, hs, expired;
  logic [15:0] hdr_n, idx_inc;

  assign ready   = st_accepts(state_q);
  assign hs      = byte_valid_i & ready;
  assign hdr_n   = {byte_data_i, n_q[7:0]};
  assign idx_inc = idx_q + 16'd1;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (hs | ~ready),
    .en_i      (ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    n_d     = n_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_HDR0;
          idx_d   = '0;
          lane_d  = '0;
        end
      end
      ST_HDR0: begin
        if (hs) begin
          n_d[7:0] = byte_data_i;
          state_d  = ST_HDR1;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_HDR1: begin
        if (hs) begin
          n_d    = hdr_n;
          lane_d = '0;
          if (hdr_n == 16'd0)                     state_d = ST_DONE;
          else if ({1'b0, hdr_n} > 17'(DEPTH))    state_d = ST_ERR;
          else                                    state_d = ST_DATA;
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA: begin
        if (hs) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: asm_d[7:0]   = byte_data_i;
            2'd1: asm_d[15:8]  = byte_data_i;
            2'd2: asm_d[23:16] = byte_data_i;
            default: begin
              // Latch the full word and its address now so they are stable
              // throughout the WRITE cycle and hold afterwards.
              wdata_d = {byte_data_i, asm_q};
              addr_d  = {14'd0, idx_q, 2'b00};
              state_d = ST_WRITE;
            end
          endcase
        end else if (expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == n_q) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      asm_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign byte_ready_o   = ready;
  assign mem_we_o       = (state_q == ST_WRITE);
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign busy_o         = ready | (state_q == ST_WRITE);
  assign done_o         = (state_q == ST_DONE);
  assign error_o        = (state_q == ST_ERR);
  assign words_loaded_o = idx_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (DEPTH=1024, TIMEOUT=50).
module tb_instr_mem_loader;

  localparam int DEPTH = 1024;
  localparam int TO    = 50;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, bv = 1'b0;
  logic [7:0]  bd = 8'h00;
  logic        ready, mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_pass = 0, n_total = 0;

  instr_mem_loader #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .byte_data_i(bd), .byte_valid_i(bv), .byte_ready_o(ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .done_o(done), .error_o(error), .words_loaded_o(words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n && mem_we) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: addr %h data %h with empty scoreboard", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr === e.a && mem_wdata === e.d) n_pass++;
        else $display("FAIL mem_write: got %h/%h expected %h/%h", mem_addr, mem_wdata, e.a, e.d);
      end
    end
  end

  // All tasks start and end aligned at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    repeat (gap) begin @(posedge clk); #1; end
    bd = b; bv = 1'b1; r = 1'b0;
    for (int k = 0; k < 100 && !r; k++) begin
      @(negedge clk); r = ready;
      @(posedge clk); #1;
    end
    bv = 1'b0;
    if (!r) begin
      n_total++;
      $display("FAIL byte_handshake: byte %h not accepted within 100 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);   send_byte(w[15:8], gap);
    send_byte(w[23:16], gap); send_byte(w[31:24], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] ii;
    // Reset state
    #1;
    chk("rst_we", {31'd0, mem_we}, 0);   chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);      chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);   chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, error}, 0);   chk("rst_words", {16'd0, words}, 0);
    @(negedge clk); rst_n = 1'b1; step();

    // 1: two-word stream
    exp_q.push_back('{32'h0, 32'h00000013});
    exp_q.push_back('{32'h4, 32'h00100093});
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 1);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00000013, 0); send_word(32'h00100093, 0);
    step();
    chk("t1_done", {31'd0, done}, 1);    chk("t1_words", {16'd0, words}, 2);
    chk("t1_busy0", {31'd0, busy}, 0);   chk("t1_ready0", {31'd0, ready}, 0);

    // 2: empty image
    pulse_start();
    chk("t2_done_clr", {31'd0, done}, 0); chk("t2_ready", {31'd0, ready}, 1);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("t2_done", {31'd0, done}, 1);     chk("t2_words", {16'd0, words}, 0);

    // 3: N = 1025 > DEPTH
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    chk("t3_err", {31'd0, error}, 1);     chk("t3_ready", {31'd0, ready}, 0);
    chk("t3_done", {31'd0, done}, 0);     chk("t3_words", {16'd0, words}, 0);

    // 4: stall after two data bytes -> ERR on the 50th idle cycle
    pulse_start();
    chk("t4_err_clr", {31'd0, error}, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    repeat (TO - 1) step();
    chk("t4_err_49", {31'd0, error}, 0);
    step();
    chk("t4_err_50", {31'd0, error}, 1);  chk("t4_words", {16'd0, words}, 0);
    exp_q.push_back('{32'h0, 32'hDEADBEEF});
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'hDEADBEEF, 0);
    step();
    chk("t4_done", {31'd0, done}, 1);     chk("t4_err0", {31'd0, error}, 0);

    // 5: reset during the write of word index 2 of 8
    pulse_start();
    send_byte(8'h08, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) exp_q.push_back('{32'(i * 4), 32'h10000000 + 32'(i)});
      send_word(32'h10000000 + 32'(i), 0);
    end
    chk("t5_we_before", {31'd0, mem_we}, 1);
    rst_n = 1'b0; #1;
    chk("t5_we", {31'd0, mem_we}, 0);     chk("t5_addr", mem_addr, 0);
    chk("t5_wdata", mem_wdata, 0);        chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_words", {16'd0, words}, 0);   chk("t5_done", {31'd0, done}, 0);
    @(negedge clk); rst_n = 1'b1; step();
    chk("t5_ready", {31'd0, ready}, 0);   chk("t5_idle_busy", {31'd0, busy}, 0);

    // 6: full-depth image, random gaps, START pulses while busy
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ii = 16'(i);
      exp_q.push_back('{32'(i * 4), {~ii, ii}});
      if (i % 97 == 5) pulse_start();
      send_word({~ii, ii}, int'($urandom_range(0, 3)));
    end
    step();
    chk("t6_done", {31'd0, done}, 1);     chk("t6_words", {16'd0, words}, DEPTH);
    chk("t6_last_addr", mem_addr, 32'hFFC);
    chk("t6_last_data", mem_wdata, 32'hFC0003FF);
    chk("t6_err", {31'd0, error}, 0);
    step(); step();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
